// File: rtl/seq_det_pkg.sv
// Purpose : shared types, default widths and config helpers for the sequence detector.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package seq_det_pkg;

  localparam int W_DEF       = 8;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int LEN_W       = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Lengths outside 2..pat_max fall back to the longest supported pattern.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int pat_max);
    if (len < 4'd2 || int'(len) > pat_max) return LEN_W'(pat_max);
    return len;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Purpose : word-wide valid/ready stream from the producer into the detector.
// Latency : n/a (wiring only).
// Backpressure : producer holds in_valid/in_data until in_ready is seen high.
// Ports   : in_valid/in_data driven by master, in_ready driven by slave.
interface seq_det_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_det_match.sv
// Purpose : overlapping bit-serial pattern matcher (history, valid count, compare).
// Latency : bit presented in cycle N -> match pulse in cycle N+1; hit is same-cycle.
// Backpressure : none; consumes one bit per cycle whenever bit_vld is high.
// Ports   : clk/rst, clr (history wipe), bit_vld/bit_dat, pattern/len (config),
//           hit (combinational), match (registered pulse).
module seq_det_match #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               bit_vld,
  input  logic               bit_dat,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit,
  output logic               match
);

  localparam int VW = $clog2(PAT_MAX + 1);
  localparam logic [VW-1:0] VCNT_SAT = VW'(PAT_MAX);

  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_nxt;
  logic [VW-1:0]      vcnt;
  logic               pat_eq;

  // Compare against the history as it will be after this bit lands, so the
  // newest bit sits at index 0 alongside pattern[0].
  always_comb begin
    hist_nxt = {hist[PAT_MAX-2:0], bit_dat};
    pat_eq   = 1'b1;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(len) && hist_nxt[i] != pattern[i]) pat_eq = 1'b0;
    end
    hit = bit_vld & ((int'(vcnt) + 1) >= int'(len)) & pat_eq;
  end

  // History is kept on a hit so overlapping occurrences are all reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '0;
      vcnt  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (clr) begin
        hist <= '0;
        vcnt <= '0;
      end else if (bit_vld) begin
        hist <= hist_nxt;
        if (vcnt != VCNT_SAT) vcnt <= vcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Purpose : accepts words, serialises MSB-first into the matcher, counts matches, sticky irq.
// Latency : word taken in cycle T -> bit i matched, match pulse in cycle T+2+i.
// Backpressure : in_ready only in IDLE (no cfg_wr) or on the last bit of a word, gated by en.
// Ports   : clk/rst; en; cfg_wr/cfg_pattern/cfg_len/cfg_thresh/cfg_ready; word_if
//           (in_valid/in_data/in_ready); busy; match; match_cnt; irq/irq_clr.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_wr,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic               cfg_ready,
  seq_det_if.slave           word_if,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  input  logic               irq_clr
);

  localparam int BCW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [BCW-1:0]     bit_cnt;
  logic [W-1:0]       shreg;
  logic               in_ready;
  logic               xfer;
  logic               cfg_take;
  logic               last_bit;

  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   thresh_q;

  logic               hit;
  logic               inc_q;
  logic               cnt_sat;

  assign last_bit         = (bit_cnt == BIT_LAST);
  assign cfg_take         = (state == ST_IDLE) & cfg_wr;
  assign xfer             = word_if.in_valid & in_ready;
  assign word_if.in_ready = in_ready;
  assign cnt_sat          = &match_cnt;

  // Next state and handshake outputs. A config write in IDLE blocks the
  // word handshake for that cycle so the new config applies to the word.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = en & ~cfg_wr;
        if (xfer) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        in_ready = en & last_bit;
        if (last_bit) state_nxt = xfer ? ST_SHIFT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Data shift register: MSB is the bit currently presented to the matcher.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (xfer) begin
      bit_cnt <= '0;
      shreg   <= word_if.in_data;
    end else if (state == ST_SHIFT) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      shreg   <= {shreg[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= '0;
      len_q    <= LEN_W'(PAT_MAX);
      thresh_q <= '0;
    end else if (cfg_take) begin
      pat_q    <= cfg_pattern;
      len_q    <= clamp_len(cfg_len, PAT_MAX);
      thresh_q <= cfg_thresh;
    end
  end

  seq_det_match #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_take),
    .bit_vld (state == ST_SHIFT),
    .bit_dat (shreg[W-1]),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit),
    .match   (match)
  );

  // inc_q marks a cycle in which match_cnt has just moved, so the irq fires
  // only on the transition onto the threshold and never while parked there.
  always_ff @(posedge clk) begin
    if (rst || cfg_take) begin
      match_cnt <= '0;
      inc_q     <= 1'b0;
    end else begin
      inc_q <= hit & ~cnt_sat;
      if (hit && !cnt_sat) match_cnt <= match_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_take) begin
      irq <= 1'b0;
    end else if (inc_q && (thresh_q != '0) && (match_cnt == thresh_q)) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  localparam int W  = 8;
  localparam int PM = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_wr;
  logic [PM-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic [CW-1:0] cfg_thresh;
  logic          irq_clr;
  logic          cfg_ready;
  logic          busy;
  logic          match;
  logic          irq;
  logic [CW-1:0] match_cnt;

  seq_det_if #(.W(W)) u_if ();

  seq_det_ctrl #(.W(W), .PAT_MAX(PM), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .cfg_ready   (cfg_ready),
    .word_if     (u_if),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int cnt;
    bit irq;
  } exp_t;

  exp_t          sbq[$];
  bit            hist[$];
  int            m_len;
  logic [PM-1:0] m_pat;
  int            m_thr;
  int            m_cnt;
  int            irq_rise;
  bit            chk_irq = 1'b0;

  function automatic void model_cfg(input logic [PM-1:0] pat, input int len, input int thr);
    m_pat    = pat;
    m_len    = (len >= 2 && len <= PM) ? len : PM;
    m_thr    = thr;
    m_cnt    = 0;
    irq_rise = -1;
    hist.delete();
  endfunction

  // Bits of the word arrive oldest-first; pattern bit 0 is the newest bit.
  function automatic void model_word(input logic [W-1:0] d, input int t);
    for (int i = 0; i < W; i++) begin
      bit ok;
      hist.push_back(d[W-1-i]);
      if (hist.size() > PM) void'(hist.pop_front());
      if (hist.size() >= m_len) begin
        ok = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (hist[hist.size()-1-k] != m_pat[k]) ok = 1'b0;
        if (ok) begin
          exp_t e;
          e.cyc = t + 2 + i;
          if (m_cnt < (2**CW - 1)) begin
            m_cnt++;
            if (m_thr != 0 && m_cnt == m_thr) irq_rise = e.cyc + 1;
          end
          e.cnt = m_cnt;
          e.irq = (irq_rise >= 0) && (e.cyc >= irq_rise);
          sbq.push_back(e);
        end
      end
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      chk("missed_match_cycle", cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (match) begin
      if (sbq.size() == 0) begin
        chk("spurious_match", match, 0);
      end else begin
        e = sbq.pop_front();
        chk("match_cycle", cyc, e.cyc);
        chk("match_cnt", match_cnt, e.cnt);
        if (chk_irq) chk("irq_at_match", irq, e.irq);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    u_if.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [W-1:0] d, output int t);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    t = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (u_if.in_ready) begin
        t = cyc;
        model_word(d, cyc);
      end
      tick();
      if (t >= 0) break;
    end
    if (t < 0) chk("accept_timeout", t, 0);
  endtask

  task automatic do_cfg(input logic [PM-1:0] pat, input int len, input int thr);
    bit ok;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_thresh  = CW'(thr);
    cfg_wr      = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1'b1;
        model_cfg(pat, len, thr);
      end
      tick();
      if (ok) break;
    end
    cfg_wr = 1'b0;
    if (!ok) chk("cfg_timeout", ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
    model_cfg('0, PM, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t, t1, t2;
    rst           = 1'b1;
    en            = 1'b0;
    cfg_wr        = 1'b0;
    cfg_pattern   = '0;
    cfg_len       = '0;
    cfg_thresh    = '0;
    irq_clr       = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
    model_cfg('0, PM, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", u_if.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_irq", irq, 0);
    tick();
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Pattern 101, single word A8: two overlapping hits.
    do_cfg(8'h05, 3, 0);
    send_word(8'hA8, t);
    idle(12);
    @(negedge clk);
    chk("t1_match_cnt", match_cnt, 2);
    tick();

    // Back-to-back words with in_valid held; match spans the word boundary.
    send_word(8'h02, t1);
    send_word(8'h80, t2);
    idle(12);
    chk("b2b_accept_gap", t2 - t1, 8);
    @(negedge clk);
    chk("t2_match_cnt", match_cnt, 3);
    tick();

    // Threshold 2; irq_clr coincides with the set cycle, then clears alone.
    do_cfg(8'h05, 3, 2);
    send_word(8'hA8, t);
    u_if.in_valid = 1'b0;
    wait_until(t + 6);
    irq_clr = 1'b1;
    @(negedge clk);
    chk("irq_before_set", irq, 0);
    chk("irq_cnt_at_thresh", match_cnt, 2);
    tick();
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_set_wins_clr", irq, 1);
    tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_cleared", irq, 0);
    idle(6);

    // cfg_wr and word offered in the same IDLE cycle.
    cfg_pattern   = 8'h06;
    cfg_len       = 4'd4;
    cfg_thresh    = '0;
    cfg_wr        = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h36;
    @(negedge clk);
    chk("cfg_blocks_in_ready", u_if.in_ready, 0);
    chk("cfg_ready_idle", cfg_ready, 1);
    model_cfg(8'h06, 4, 0);
    tick();
    cfg_wr = 1'b0;
    @(negedge clk);
    chk("cfg_cleared_cnt", match_cnt, 0);
    chk("word_after_cfg_ready", u_if.in_ready, 1);
    if (u_if.in_ready) model_word(8'h36, cyc);
    tick();
    idle(12);

    // en dropped at bit 3: word completes, next word refused, back to IDLE.
    send_word(8'h3C, t);
    u_if.in_data = 8'h5A;
    wait_until(t + 4);
    en = 1'b0;
    wait_until(t + 8);
    @(negedge clk);
    chk("en_drop_in_ready_last", u_if.in_ready, 0);
    chk("en_drop_busy_last", busy, 1);
    tick();
    @(negedge clk);
    chk("en_drop_busy_after", busy, 0);
    chk("en_drop_cfg_ready", cfg_ready, 1);
    u_if.in_valid = 1'b0;
    en = 1'b1;
    idle(12);

    // Reset in the middle of a word that would otherwise produce hits.
    do_cfg(8'h05, 3, 1);
    send_word(8'hA8, t);
    u_if.in_valid = 1'b0;
    wait_until(t + 3);
    do_reset();
    @(negedge clk);
    chk("midrst_match", match, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_match_cnt", match_cnt, 0);
    chk("midrst_irq", irq, 0);
    idle(12);

    // Randomised rounds against the model.
    chk_irq = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int len, thr, nw;
      logic [PM-1:0] pat;
      pat = PM'($urandom);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 8);
      thr = $urandom_range(0, 4);
      do_cfg(pat, len, thr);
      nw = $urandom_range(3, 10);
      for (int w = 0; w < nw; w++) begin
        logic [W-1:0] d;
        d = ($urandom_range(0, 1) == 0) ? W'($urandom) : {2{pat[3:0]}};
        send_word(d, t);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(12);
      @(negedge clk);
      chk("irq_round_end", irq, (irq_rise >= 0) ? 1 : 0);
      chk("cnt_round_end", match_cnt, m_cnt);
      tick();
    end

    idle(15);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
